// File: rtl/decode_rr_scheduler_if.sv
// decode_rr_scheduler_if
// Bundles the request/grant signals shared by the round-robin scheduler and
// the four requesters plus the 2-to-4 decoder it feeds.
//   req     : request vector, bit i = requester i        (requesters -> scheduler)
//   done    : current grantee finished                   (requesters -> scheduler)
//   sel0    : decoder select LSB (granted index bit 0)   (scheduler -> decoder)
//   sel1    : decoder select MSB (granted index bit 1)   (scheduler -> decoder)
//   gnt     : one-hot registered grant                   (scheduler -> requesters)
//   busy    : a grant is active                          (scheduler -> requesters)
//   timeout : one-cycle pulse on forced release          (scheduler -> requesters)
// The master modport is the scheduler side; the slave modport is the
// requester/decoder side.
interface decode_rr_scheduler_if;
   logic [3:0] req;
   logic       done;
   logic       sel0;
   logic       sel1;
   logic [3:0] gnt;
   logic       busy;
   logic       timeout;

   modport master (
      input  req,
      input  done,
      output sel0,
      output sel1,
      output gnt,
      output busy,
      output timeout
   );

   modport slave (
      output req,
      output done,
      input  sel0,
      input  sel1,
      input  gnt,
      input  busy,
      input  timeout
   );
endinterface

// File: rtl/decode_rr_scheduler.sv
// decode_rr_scheduler
// Round-robin scheduler sharing the 4-way decoded output path among four
// requesters. It drives the select pair consumed by the 2-to-4 decoder and a
// registered one-hot grant. A grant is held until the grantee signals done,
// drops its request, or reaches MAX_HOLD cycles. One idle arbitration cycle
// always separates consecutive grants.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : decode_rr_scheduler_if.master (req, done in; sel0, sel1, gnt,
//         busy, timeout out)
module decode_rr_scheduler #(
   parameter int MAX_HOLD = 15,
   parameter int CW       = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   decode_rr_scheduler_if.master  bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state_reg, state_next;
   logic [3:0]      gnt_reg, gnt_next;
   logic [1:0]      sel_reg, sel_next;
   logic            busy_reg, busy_next;
   logic            timeout_reg, timeout_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [1:0]      last_reg, last_next;

   // Requests rotated so that bit k is requester (last+1+k) mod 4; the lowest
   // set bit is then the round-robin winner.
   logic [3:0]      rot_req;
   logic [1:0]      win_idx;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_rot
         localparam logic [1:0] OFS = 2'((gi + 1) % 4);
         assign rot_req[gi] = bus.req[last_reg + OFS];
      end
   endgenerate

   always_comb begin
      win_idx = last_reg + 2'd1;
      for (int k = 3; k >= 0; k--) begin
         if (rot_req[k]) begin
            win_idx = last_reg + 2'(k + 1);
         end
      end
   end

   // While in GRANT the select register holds the granted index, so it is
   // used directly to look up the grantee's request bit.
   logic hold_limit;
   logic normal_release;
   assign hold_limit     = (cnt_reg == CW'(MAX_HOLD - 1));
   assign normal_release = bus.done || !bus.req[sel_reg];

   always_comb begin
      state_next   = state_reg;
      gnt_next     = gnt_reg;
      sel_next     = sel_reg;
      busy_next    = busy_reg;
      timeout_next = 1'b0;
      cnt_next     = cnt_reg;
      last_next    = last_reg;

      unique case (state_reg)
         IDLE: begin
            gnt_next  = 4'b0000;
            busy_next = 1'b0;
            cnt_next  = '0;
            if (bus.req != 4'b0000) begin
               state_next = GRANT;
               gnt_next   = 4'b0001 << win_idx;
               sel_next   = win_idx;
               busy_next  = 1'b1;
            end
         end
         GRANT: begin
            if (normal_release || hold_limit) begin
               // Select lines keep the last index so the decoder input
               // never glitches back to zero between grants.
               state_next   = IDLE;
               gnt_next     = 4'b0000;
               busy_next    = 1'b0;
               cnt_next     = '0;
               last_next    = sel_reg;
               timeout_next = hold_limit && !normal_release;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         gnt_reg     <= 4'b0000;
         sel_reg     <= 2'b00;
         busy_reg    <= 1'b0;
         timeout_reg <= 1'b0;
         cnt_reg     <= '0;
         last_reg    <= 2'd3;
      end else begin
         state_reg   <= state_next;
         gnt_reg     <= gnt_next;
         sel_reg     <= sel_next;
         busy_reg    <= busy_next;
         timeout_reg <= timeout_next;
         cnt_reg     <= cnt_next;
         last_reg    <= last_next;
      end
   end

   assign bus.gnt     = gnt_reg;
   assign bus.sel0    = sel_reg[0];
   assign bus.sel1    = sel_reg[1];
   assign bus.busy    = busy_reg;
   assign bus.timeout = timeout_reg;

endmodule

// File: tb/tb_decode_rr_scheduler.sv
// tb_decode_rr_scheduler
// Scoreboard bench: the stimulus process drives req/done on the falling edge,
// advances a behavioural model of the arbitration rules and queues the
// expected outputs; a monitor pops one entry after each rising edge and
// compares gnt, sel, busy and timeout. Reset behaviour is checked directly.
module tb_decode_rr_scheduler;
   localparam int MAX_HOLD = 15;
   localparam int CW       = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   decode_rr_scheduler_if bus();

   decode_rr_scheduler #(.MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       busy;
      logic       timeout;
   } exp_t;

   exp_t q[$];
   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Behavioural model: owner is the granted requester (-1 when none),
   // held counts cycles the current grant has been visible so far.
   int owner, held, last, msel;
   bit mto;

   function automatic void model_reset();
      owner = -1;
      held  = 0;
      last  = 3;
      msel  = 0;
      mto   = 1'b0;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Applies one cycle of inputs at a falling edge, predicts the outputs
   // visible after the next rising edge, then moves to the next falling edge.
   task automatic step(input logic [3:0] r, input logic d);
      exp_t e;
      bus.req  = r;
      bus.done = d;
      mto = 1'b0;
      if (owner < 0) begin
         if (r != 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
               int i;
               i = (last + k) % 4;
               if (r[i]) begin
                  owner = i;
                  held  = 1;
                  msel  = i;
                  break;
               end
            end
         end
      end else if (d || !r[owner]) begin
         last  = owner;
         owner = -1;
      end else if (held == MAX_HOLD) begin
         last  = owner;
         owner = -1;
         mto   = 1'b1;
      end else begin
         held++;
      end
      e.gnt     = (owner < 0) ? 4'b0000 : 4'(1 << owner);
      e.sel     = 2'(msel);
      e.busy    = (owner >= 0);
      e.timeout = mto;
      q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: one comparison set per queued transaction.
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
         e = q.pop_front();
         $display("[TB] cyc %0d req=%b done=%b gnt=%b sel=%b%b busy=%b to=%b",
                  cyc, bus.req, bus.done, bus.gnt, bus.sel1, bus.sel0, bus.busy, bus.timeout);
         chk("gnt",     {4'b0, bus.gnt},             {4'b0, e.gnt});
         chk("sel",     {6'b0, bus.sel1, bus.sel0},  {6'b0, e.sel});
         chk("busy",    {7'b0, bus.busy},            {7'b0, e.busy});
         chk("timeout", {7'b0, bus.timeout},         {7'b0, e.timeout});
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] r;
      logic       d;
      model_reset();
      bus.req  = 4'b1111;
      bus.done = 1'b0;

      // Reset asserted with all requesting: everything cleared.
      #1;
      chk("rst_gnt",  {4'b0, bus.gnt},                {8'h00});
      chk("rst_sel",  {6'b0, bus.sel1, bus.sel0},     {8'h00});
      chk("rst_busy", {7'b0, bus.busy},               {8'h00});
      chk("rst_to",   {7'b0, bus.timeout},            {8'h00});
      repeat (3) @(negedge clk);
      chk("rst_hold_gnt", {4'b0, bus.gnt}, {8'h00});
      rst = 1'b0;

      // First grant after reset goes to requester 0.
      step(4'b1111, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);

      // Single requester held three cycles, released by done.
      step(4'b0100, 1'b0);
      step(4'b0100, 1'b0);
      step(4'b0100, 1'b0);
      step(4'b0100, 1'b1);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);

      // Rotation with done in every grant's first cycle.
      repeat (6) begin
         step(4'b1111, 1'b0);
         step(4'b1111, 1'b1);
      end
      step(4'b0000, 1'b0);

      // Forced release at the hold limit, then regrant.
      repeat (36) step(4'b0010, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);

      // Request drop mid-grant.
      repeat (3) step(4'b0100, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);

      // done coinciding with the hold limit: normal release.
      step(4'b0001, 1'b0);
      repeat (14) step(4'b0001, 1'b0);
      step(4'b0001, 1'b1);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);

      // Random traffic: slowly changing requests, occasional done.
      r = 4'($urandom_range(0, 15));
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 7) == 0) r = 4'($urandom_range(0, 15));
         d = ($urandom_range(0, 9) == 0);
         step(r, d);
      end
      // Random traffic without done so the hold limit is exercised.
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 31) == 0) r = 4'($urandom_range(1, 15));
         step(r, 1'b0);
      end

      // Reset mid-grant while requester 3 owns the path.
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b1000, 1'b0);
      step(4'b1000, 1'b0);
      step(4'b1000, 1'b0);
      chk("pre_rst_gnt", {4'b0, bus.gnt}, {8'h08});
      #2;
      rst = 1'b1;
      #1;
      chk("async_gnt",  {4'b0, bus.gnt},            {8'h00});
      chk("async_sel",  {6'b0, bus.sel1, bus.sel0}, {8'h00});
      chk("async_busy", {7'b0, bus.busy},           {8'h00});
      chk("async_to",   {7'b0, bus.timeout},        {8'h00});
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(4'b1001, 1'b0);
      step(4'b1001, 1'b1);
      step(4'b1001, 1'b0);
      step(4'b1001, 1'b0);
      step(4'b0000, 1'b0);

      chk("queue_drained", 8'(q.size()), 8'h00);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
